alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//  Synthesisable, parametrised command engine for a TinyALU-style multi-cycle ALU (start/done handshake).
//  Queues commands from a valid/ready source, issues them one at a time and returns tagged results on a valid/ready sink.
//  Adds a done-timeout with automatic ALU recovery reset, illegal-op flagging and backpressure.
//  Sits between the test/system controller and the ALU core; the ALU core is the only consumer of the alu_* ports.
// PARAMETERS
//  DATA_W      8    operand width; result width is 2*DATA_W
//  DEPTH       4    command FIFO entries, power of two, >=2
//  TIMEOUT_CYC 64   max cycles alu_start may stay high without alu_done before abort, >=2
// PORTS
//  clk         in   1         clock, all logic on posedge
//  reset       in   1         asynchronous, active-high reset
//  cmd_valid   in   1         command offered
//  cmd_ready   out  1         FIFO can accept (= !full)
//  cmd_a       in   DATA_W    operand A
//  cmd_b       in   DATA_W    operand B
//  cmd_op      in   3         000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op, 101/110 illegal
//  alu_a       out  DATA_W    operand A to ALU, held while alu_start high
//  alu_b       out  DATA_W    operand B to ALU, held while alu_start high
//  alu_op      out  3         opcode to ALU, held while alu_start high
//  alu_start   out  1         start request to ALU
//  alu_done    in   1         ALU completion, sampled on posedge
//  alu_result  in   2*DATA_W  ALU result, valid when alu_done high
//  alu_rst     out  1         one-cycle active-high reset pulse to ALU
//  rsp_valid   out  1         response available
//  rsp_ready   in   1         response consumed
//  rsp_result  out  2*DATA_W  captured result (0 on timeout/illegal)
//  rsp_op      out  3         opcode the response belongs to
//  rsp_timeout out  1         response produced by timeout abort
//  rsp_illegal out  1         response produced by illegal opcode
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, all outputs 0 except cmd_ready=1; reset mid-operation drops everything, no response.
//  FIFO: push on cmd_valid&&cmd_ready; pop on entry to ISSUE/RST/ILL; push+pop same cycle allowed; no bypass; pointers wrap mod DEPTH.
//  Full: cmd_ready=0 with DEPTH entries even if a pop occurs that cycle (ready registered from count).
//  States: IDLE, ISSUE, WAIT_DONE, RSP, ALU_RST.
//  IDLE: if FIFO non-empty and rsp_valid==0, pop head and decode: add/and/xor/mul -> ISSUE; no_op -> ISSUE (one-shot);
//   rst_op -> ALU_RST; illegal -> RSP with rsp_illegal=1, rsp_result=0.
//  ISSUE: alu_start=1, alu_a/b/op = command; no_op returns to IDLE after this single cycle, no response; others -> WAIT_DONE.
//  WAIT_DONE: alu_start stays 1; timer counts cycles since ISSUE; alu_done=1 -> capture alu_result, alu_start=0 next cycle, -> RSP.
//  Timeout: timer reaches TIMEOUT_CYC without done -> alu_start=0, response with rsp_timeout=1, result 0, then ALU_RST.
//  Done and timeout on the same edge: done wins, no timeout flag.
//  RSP: rsp_valid=1 held with stable fields until rsp_ready; on handshake -> IDLE (or ALU_RST if timeout).
//  ALU_RST: alu_rst=1 for exactly one cycle, alu_start=0, -> IDLE; rst_op produces no response.
//  Latency: command into empty FIFO at edge N -> alu_start high after edge N+2; done sampled at edge M -> rsp_valid after edge M+1.
//  Back-to-back: at least one IDLE cycle with alu_start=0 between commands (ALU sees a start falling edge).
//  alu_done outside WAIT_DONE is ignored; rsp_ready while rsp_valid=0 has no effect.
//  Result width: alu_result captured unmodified into 2*DATA_W rsp_result, no truncation or sign handling.
// TESTING
//  add A=8'h12 B=8'h34, ALU done after 3 cycles with 16'h0046 -> one rsp, rsp_op=001, result 16'h0046, flags 0.
//  push 5 cmds with DEPTH=4, ALU stalled -> cmd_ready drops after 4th push, 5th accepted after first pop; order preserved.
//  mul A=8'hFF B=8'hFF, rsp_ready low 10 cycles -> rsp_valid and result 16'hFE01 held stable, next cmd not issued.
//  xor with alu_done never asserted, TIMEOUT_CYC=64 -> rsp_timeout=1 result 0, then single alu_rst pulse, queue resumes.
//  op 3'b101 then no_op then rst_op -> one rsp_illegal=1, one-cycle alu_start, one alu_rst pulse, one response total.
//  reset asserted during WAIT_DONE with 2 queued -> all outputs 0, cmd_ready=1, no response after release.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command engine for a multi-cycle start/done ALU. Commands are queued in a
//   small FIFO, issued one at a time, and results come back tagged with their
//   opcode on a valid/ready response port. A done-timeout aborts a hung ALU,
//   reports the abort and then pulses the ALU reset. Illegal opcodes are
//   answered directly without touching the ALU.
// Ports
//   clk, reset                     clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_a/b/op command input (ready = FIFO not full)
//   alu_a/b/op, alu_start          ALU request, held while alu_start high
//   alu_done, alu_result           ALU completion and its result
//   alu_rst                        one-cycle ALU reset pulse
//   rsp_valid/rsp_ready            response handshake
//   rsp_result/op/timeout/illegal  response payload
module alu_cmd_sequencer #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic [2:0]          cmd_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_op,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                alu_rst,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic [2:0]          rsp_op,
  output logic                rsp_timeout,
  output logic                rsp_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    OP_NOP = 3'b000;
  localparam logic [2:0]    OP_RST = 3'b111;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RSP, ALU_RST} state_t;
  state_t state_q, state_d;

  // command FIFO
  logic [DATA_W-1:0] mem_a  [DEPTH];
  logic [DATA_W-1:0] mem_b  [DEPTH];
  logic [2:0]        mem_op [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop;
  logic [2:0]        head_op;
  logic              head_ill;

  // command being executed
  logic [DATA_W-1:0] cur_a, cur_b;
  logic [2:0]        cur_op;
  logic [TW-1:0]     timer;
  logic              tmo;

  // Ready comes from the registered count only, so a full FIFO stays
  // not-ready on the cycle it pops.
  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign head_op   = mem_op[rd_ptr];
  assign head_ill  = (head_op == 3'b101) || (head_op == 3'b110);
  // timer holds the number of WAIT_DONE edges already passed, so alu_start
  // is high for at most TIMEOUT_CYC cycles.
  assign tmo       = (timer == TO_MAX);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= cmd_a;
      mem_b[wr_ptr]  <= cmd_b;
      mem_op[wr_ptr] <= cmd_op;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0 && !rsp_valid) begin
          pop = 1'b1;
          if (head_op == OP_RST) state_d = ALU_RST;
          else if (head_ill)     state_d = RSP;
          else                   state_d = ISSUE;
        end
      end
      ISSUE:     state_d = (cur_op == OP_NOP) ? IDLE : WAIT_DONE;
      WAIT_DONE: if (alu_done || tmo) state_d = RSP;  // done wins over timeout
      RSP:       if (rsp_valid && rsp_ready) state_d = rsp_timeout ? ALU_RST : IDLE;
      ALU_RST:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cur_a       <= '0;
      cur_b       <= '0;
      cur_op      <= '0;
      timer       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_start   <= 1'b0;
      alu_rst     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_timeout <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);

      // Registered start: rises one edge after ISSUE, so a no_op gives a
      // single-cycle pulse and consecutive commands always see a low cycle.
      alu_start <= (state_q == ISSUE) || (state_q == WAIT_DONE && state_d == WAIT_DONE);
      alu_rst   <= (state_d == ALU_RST);

      if (pop) begin
        cur_a  <= mem_a[rd_ptr];
        cur_b  <= mem_b[rd_ptr];
        cur_op <= head_op;
      end

      case (state_q)
        IDLE: begin
          if (pop && head_ill) begin
            rsp_op      <= head_op;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
            rsp_illegal <= 1'b1;
          end
        end
        ISSUE: begin
          alu_a  <= cur_a;
          alu_b  <= cur_b;
          alu_op <= cur_op;
          timer  <= '0;
        end
        WAIT_DONE: begin
          if (alu_done) begin
            rsp_op      <= cur_op;
            rsp_result  <= alu_result;
            rsp_timeout <= 1'b0;
            rsp_illegal <= 1'b0;
          end else if (tmo) begin
            rsp_op      <= cur_op;
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            rsp_illegal <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RSP: begin
          // valid rises one edge after entry, then holds until taken
          if (!rsp_valid)     rsp_valid <= 1'b1;
          else if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
